// File: rtl/ysyx_040066_fetch_seq.sv
// Fetch PC sequencer: owns the architectural fetch PC, issues one fetch
// request at a time, hands each fetched instruction to ID, and applies EX
// redirects. A fetch that is in flight when a redirect arrives is dropped.
module ysyx_040066_fetch_seq #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            if_req_valid,
   input  logic            if_req_ready,
   output logic [XLEN-1:0] if_req_addr,
   input  logic            if_rsp_valid,
   input  logic [31:0]     if_rsp_inst,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_inst,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   output logic            misalign
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_DROP = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pend_valid_q, pend_valid_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [31:0]     id_inst_q, id_inst_d;
   logic            misalign_q, misalign_d;

   logic redir_ok;
   logic redir_bad;

   // A redirect target must be word aligned; anything else halts fetch.
   assign redir_ok  = ex_redirect && (ex_target[1:0] == 2'b00);
   assign redir_bad = ex_redirect && (ex_target[1:0] != 2'b00);

   // Next-state and datapath decisions for the sequencer.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      id_pc_d      = id_pc_q;
      id_inst_d    = id_inst_q;
      misalign_d   = misalign_q;

      if (redir_bad) begin
         // Sticky fault; pending redirect state is deliberately left alone.
         misalign_d = 1'b1;
         state_d    = S_HALT;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_REQ;
               if (redir_ok) begin
                  pc_d = ex_target;
               end
            end
            S_REQ: begin
               if (if_req_ready) begin
                  if (redir_ok) begin
                     // Request already accepted: its response must be thrown away.
                     pend_valid_d = 1'b1;
                     pend_pc_d    = ex_target;
                     state_d      = S_DROP;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else if (redir_ok) begin
                  // Nothing accepted yet, so the request simply retargets.
                  pc_d = ex_target;
               end
            end
            S_WAIT: begin
               if (if_rsp_valid) begin
                  if (redir_ok) begin
                     pc_d    = ex_target;
                     state_d = S_REQ;
                  end else begin
                     id_inst_d = if_rsp_inst;
                     id_pc_d   = pc_q;
                     state_d   = S_HOLD;
                  end
               end else if (redir_ok) begin
                  pend_valid_d = 1'b1;
                  pend_pc_d    = ex_target;
                  state_d      = S_DROP;
               end
            end
            S_DROP: begin
               if (if_rsp_valid) begin
                  // Latest redirect wins, including one arriving with the response.
                  if (redir_ok) begin
                     pc_d = ex_target;
                  end else if (pend_valid_q) begin
                     pc_d = pend_pc_q;
                  end
                  pend_valid_d = 1'b0;
                  state_d      = S_REQ;
               end else if (redir_ok) begin
                  pend_valid_d = 1'b1;
                  pend_pc_d    = ex_target;
               end
            end
            S_HOLD: begin
               if (redir_ok) begin
                  pc_d    = ex_target;
                  state_d = S_REQ;
               end else if (id_ready) begin
                  pc_d    = pc_q + XLEN'(4);
                  state_d = S_REQ;
               end
            end
            S_HALT: begin
               state_d = S_HALT;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         id_pc_q      <= '0;
         id_inst_q    <= '0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         id_pc_q      <= id_pc_d;
         id_inst_q    <= id_inst_d;
         misalign_q   <= misalign_d;
      end
   end

   // Request and delivery valids are decoded from state, so they are mutually exclusive.
   assign if_req_valid = (state_q == S_REQ);
   assign if_req_addr  = pc_q;
   assign id_valid     = (state_q == S_HOLD);
   assign id_pc        = id_pc_q;
   assign id_inst      = id_inst_q;
   assign misalign     = misalign_q;

endmodule

// File: tb/tb_ysyx_040066_fetch_seq.sv
// Bench for the fetch sequencer: transaction-level reference model, one
// per-cycle compare process, directed scenarios with literal expectations,
// and a randomized phase.
module tb_ysyx_040066_fetch_seq;

   localparam int          XLEN   = 64;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk;
   logic        rst_n;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_inst;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [31:0] id_inst;
   logic        ex_redirect;
   logic [63:0] ex_target;
   logic        misalign;

   ysyx_040066_fetch_seq #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req_valid(if_req_valid),
      .if_req_ready(if_req_ready),
      .if_req_addr (if_req_addr),
      .if_rsp_valid(if_rsp_valid),
      .if_rsp_inst (if_rsp_inst),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .ex_redirect (ex_redirect),
      .ex_target   (ex_target),
      .misalign    (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: next fetch PC, one outstanding fetch (maybe doomed),
   // one held instruction, halted flag.
   logic [63:0] m_pc;
   logic [63:0] m_ipc;
   logic [31:0] m_inst;
   bit m_out, m_kill, m_have, m_halt, m_mis, m_started, m_acc;

   // Memory responder
   bit          mem_busy;
   int          mem_cnt;
   int          mem_dmin = 1;
   int          mem_dmax = 1;
   bit          mem_force;
   logic [31:0] mem_force_inst;

   // Observed handshakes
   logic [63:0] req_log[$];
   logic [63:0] id_pc_log[$];
   int          id_cyc_log[$];
   bit          saw_dead;

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [63:0] req_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
   endfunction

   function automatic logic [63:0] idpc_at(input int i);
      return (i < id_pc_log.size()) ? id_pc_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
   endfunction

   function automatic int idcyc_at(input int i);
      return (i < id_cyc_log.size()) ? id_cyc_log[i] : -100;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_ipc = '0; m_inst = '0;
      m_out = 0; m_kill = 0; m_have = 0; m_halt = 0; m_mis = 0;
      m_started = 0; m_acc = 0;
   endtask

   // One clock of architectural behaviour, from the inputs presented this cycle.
   task automatic model_update();
      bit bad, ok, had, rs;
      m_acc = m_started && !m_halt && !m_out && !m_have && if_req_ready;
      if (m_halt) return;
      bad = ex_redirect && (ex_target[1:0] != 2'b00);
      ok  = ex_redirect && !bad;
      if (bad) begin
         m_halt = 1; m_mis = 1; m_have = 0; m_out = 0;
         return;
      end
      if (!m_started) begin
         m_started = 1;
         if (ok) m_pc = ex_target;
         return;
      end
      had = m_have;
      rs  = if_rsp_valid && m_out;
      if (m_acc) begin
         m_out = 1; m_kill = 0;
      end else if (rs) begin
         m_out = 0;
         if (!m_kill && !ok) begin
            m_have = 1; m_ipc = m_pc; m_inst = if_rsp_inst;
         end
      end
      if (had && id_ready && !ok) begin
         m_have = 0; m_pc = m_pc + 64'd4;
      end
      if (ok) begin
         m_pc = ex_target;
         if (m_out) m_kill = 1;
         m_have = 0;
      end
   endtask

   // Drive one cycle of inputs, advance model and memory at the clock edge.
   task automatic step(input bit rdy, input bit idr, input bit rd, input logic [63:0] tg);
      if_req_ready = rdy;
      id_ready     = idr;
      ex_redirect  = rd;
      ex_target    = tg;
      if (mem_busy && mem_cnt == 1) begin
         if_rsp_valid = 1'b1;
         if_rsp_inst  = mem_force ? mem_force_inst : $urandom;
         mem_force    = 0;
      end else begin
         if_rsp_valid = 1'b0;
         if_rsp_inst  = $urandom;
      end
      @(posedge clk);
      if (rst_n) begin
         model_update();
         if (if_rsp_valid) mem_busy = 0;
         else if (mem_busy && mem_cnt > 1) mem_cnt--;
         if (m_acc) begin
            mem_busy = 1;
            mem_cnt  = int'($urandom_range(mem_dmax, mem_dmin));
         end
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      mem_busy = 0; mem_cnt = 0; mem_force = 0;
      if_req_ready = 0; if_rsp_valid = 0; if_rsp_inst = '0;
      id_ready = 0; ex_redirect = 0; ex_target = '0;
      req_log.delete(); id_pc_log.delete(); id_cyc_log.delete();
      saw_dead = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin : cmp_p
      bit e_rv, e_idv;
      e_rv  = rst_n && m_started && !m_halt && !m_out && !m_have;
      e_idv = rst_n && m_have && !m_halt;
      chk1("if_req_valid", if_req_valid, e_rv);
      chk1("id_valid", id_valid, e_idv);
      chk1("misalign", misalign, m_mis);
      if (e_rv) chk64("if_req_addr", if_req_addr, m_pc);
      if (e_idv) begin
         chk64("id_pc", id_pc, m_ipc);
         chk64("id_inst", 64'(id_inst), 64'(m_inst));
      end
      if (!rst_n) begin
         chk64("reset_addr", if_req_addr, RST_PC);
         chk64("reset_id_pc", id_pc, 64'd0);
         chk64("reset_id_inst", 64'(id_inst), 64'd0);
      end else begin
         if (if_req_valid && if_req_ready) req_log.push_back(if_req_addr);
         if (id_valid && id_inst == 32'hDEAD_BEEF) saw_dead = 1;
         if (id_valid && id_ready) begin
            id_pc_log.push_back(id_pc);
            id_cyc_log.push_back(cyc);
            $display("deliver cycle=%0d pc=%h inst=%h", cyc, id_pc, id_inst);
         end
      end
   end

   function automatic logic [63:0] rand_target();
      logic [63:0] t;
      case ($urandom_range(3, 0))
         0: t = 64'h8000_0000 + 64'({$urandom_range(255, 0), 2'b00});
         1: t = {$urandom, $urandom};
         2: t = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255, 0));
         default: t = 64'h9000_0000 + 64'($urandom_range(4095, 0));
      endcase
      t[1:0] = 2'b00;
      return t;
   endfunction

   initial begin : watchdog
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : main
      rst_n = 1'b0;
      model_reset();

      // T1: back-to-back fetches, no stalls
      do_reset();
      mem_dmin = 1; mem_dmax = 1;
      repeat (10) step(1, 1, 0, '0);
      chk64("t1_req0", req_at(0), 64'h8000_0000);
      chk64("t1_req1", req_at(1), 64'h8000_0004);
      chk64("t1_req2", req_at(2), 64'h8000_0008);
      chk64("t1_idpc0", idpc_at(0), 64'h8000_0000);
      chk64("t1_idpc2", idpc_at(2), 64'h8000_0008);
      chk64("t1_gap01", 64'(idcyc_at(1) - idcyc_at(0)), 64'd3);
      chk64("t1_gap12", 64'(idcyc_at(2) - idcyc_at(1)), 64'd3);

      // T2: ID stall in HOLD
      do_reset();
      for (int i = 0; i < 20 && !m_have; i++) step(1, 0, 0, '0);
      if (!m_have) bound_fail("t2_hold");
      begin : t2
         logic [31:0] held;
         held = id_inst;
         repeat (5) step(1, 0, 0, '0);
         chk1("t2_id_valid", id_valid, 1'b1);
         chk64("t2_id_pc", id_pc, 64'h8000_0000);
         chk64("t2_inst_stable", 64'(id_inst), 64'(held));
         chk64("t2_no_new_req", 64'(req_log.size()), 64'd1);
      end
      step(1, 1, 0, '0);
      for (int i = 0; i < 10 && req_log.size() < 2; i++) step(1, 1, 0, '0);
      chk64("t2_next_req", req_at(1), 64'h8000_0004);

      // T3: redirect while waiting; stale response must vanish
      do_reset();
      mem_dmin = 3; mem_dmax = 3;
      mem_force = 1; mem_force_inst = 32'hDEAD_BEEF;
      for (int i = 0; i < 20 && !m_out; i++) step(1, 1, 0, '0);
      if (!m_out) bound_fail("t3_out");
      step(1, 1, 1, 64'h8000_1000);
      for (int i = 0; i < 20 && req_log.size() < 2; i++) step(1, 1, 0, '0);
      repeat (8) step(1, 1, 0, '0);
      chk64("t3_req1", req_at(1), 64'h8000_1000);
      chk64("t3_idpc0", idpc_at(0), 64'h8000_1000);
      chk1("t3_no_deadbeef", saw_dead, 1'b0);

      // T4a: redirect coincident with the response
      do_reset();
      mem_dmin = 1; mem_dmax = 1;
      for (int i = 0; i < 20 && !m_out; i++) step(1, 1, 0, '0);
      if (!m_out) bound_fail("t4a_out");
      step(1, 1, 1, 64'h8000_2000);
      chk1("t4a_req_valid", if_req_valid, 1'b1);
      chk64("t4a_req_addr", if_req_addr, 64'h8000_2000);
      repeat (6) step(1, 1, 0, '0);
      chk64("t4a_idpc0", idpc_at(0), 64'h8000_2000);

      // T4b: two redirects while dropping, latest wins
      do_reset();
      mem_dmin = 4; mem_dmax = 4;
      for (int i = 0; i < 20 && !m_out; i++) step(1, 1, 0, '0);
      if (!m_out) bound_fail("t4b_out");
      step(1, 1, 1, 64'h100);
      step(1, 1, 1, 64'h200);
      for (int i = 0; i < 20 && req_log.size() < 2; i++) step(1, 1, 0, '0);
      chk64("t4b_req1", req_at(1), 64'h200);

      // T5: redirect in HOLD with id_ready high
      do_reset();
      mem_dmin = 1; mem_dmax = 1;
      for (int i = 0; i < 20 && !m_have; i++) step(1, 0, 0, '0);
      if (!m_have) bound_fail("t5_hold");
      step(0, 1, 1, 64'h9000_0000);
      chk1("t5_req_valid", if_req_valid, 1'b1);
      chk64("t5_req_addr", if_req_addr, 64'h9000_0000);

      // T6: misaligned redirect halts until reset
      step(0, 0, 1, 64'h8000_0002);
      chk1("t6_misalign", misalign, 1'b1);
      for (int i = 0; i < 10; i++) step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, '0);
      chk1("t6_req_off", if_req_valid, 1'b0);
      chk1("t6_id_off", id_valid, 1'b0);
      chk1("t6_sticky", misalign, 1'b1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk1("t6_async_clear", misalign, 1'b0);
      do_reset();
      for (int i = 0; i < 10 && req_log.size() < 1; i++) step(1, 1, 0, '0);
      chk64("t6_resume", req_at(0), 64'h8000_0000);

      // T7: PC wraps past the top of the address space
      do_reset();
      for (int i = 0; i < 20 && !m_have; i++) step(1, 0, 0, '0);
      if (!m_have) bound_fail("t7_hold");
      step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      for (int i = 0; i < 30 && req_log.size() < 3; i++) step(1, 1, 0, '0);
      chk64("t7_req_top", req_at(1), 64'hFFFF_FFFF_FFFF_FFFC);
      chk64("t7_req_wrap", req_at(2), 64'h0);

      // Randomized phase
      mem_dmin = 1; mem_dmax = 4;
      for (int r = 0; r < 4; r++) begin
         int halt_cnt;
         do_reset();
         halt_cnt = 0;
         for (int c = 0; c < 700; c++) begin
            bit          rd;
            logic [63:0] tg;
            rd = ($urandom_range(99, 0) < 8);
            tg = rand_target();
            if ($urandom_range(999, 0) < 3) begin
               rd = 1;
               tg[1:0] = 2'($urandom_range(3, 1));
            end
            step(($urandom_range(99, 0) < 60), ($urandom_range(99, 0) < 60), rd, tg);
            if (m_halt) begin
               halt_cnt++;
               if (halt_cnt > 15) begin
                  do_reset();
                  halt_cnt = 0;
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
